// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// Holds the FSM encoding, owner codes and default bus widths.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  localparam logic OWNER_F = 1'b0;
  localparam logic OWNER_E = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts BUSY cycles without mem_ready; expired marks the cycle whose
// edge would complete TIMEOUT_CYCLES stalled cycles.
module mem_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between fetch (F) and execute (E) with
// E priority bounded by a streak limit and a per-access timeout guard.
//
// state | meaning
// IDLE  | sample requests, grant and launch strobe on the same edge
// BUSY  | strobe held, wait for mem_ready or timeout
// DONE  | one cycle with the owner's done/err pulse high
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MAX_E_STREAK   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_done,
  output logic              f_err,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              e_req,
  input  logic              e_we,
  input  logic [ADDR_W-1:0] e_addr,
  input  logic [DATA_W-1:0] e_wdata,
  output logic              e_done,
  output logic              e_err,
  output logic [DATA_W-1:0] e_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              owner,
  output logic              timeout_flag
);

  localparam int SW = $clog2(MAX_E_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_E_STREAK);

  arb_state_t        state, state_n;
  logic [SW-1:0]     streak, streak_n;
  logic              owner_n, busy_n, timeout_flag_n;
  logic              mem_read_n, mem_write_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [DATA_W-1:0] mem_wdata_n, f_rdata_n, e_rdata_n;
  logic              f_done_n, f_err_n, e_done_n, e_err_n;
  logic              grant_e, grant_f;
  logic              tmo_clear, tmo_en, tmo_expired;

  mem_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmo_clear),
    .enable (tmo_en),
    .expired(tmo_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      streak       <= '0;
      owner        <= OWNER_F;
      busy         <= 1'b0;
      timeout_flag <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      f_rdata      <= '0;
      e_rdata      <= '0;
      f_done       <= 1'b0;
      f_err        <= 1'b0;
      e_done       <= 1'b0;
      e_err        <= 1'b0;
    end else begin
      state        <= state_n;
      streak       <= streak_n;
      owner        <= owner_n;
      busy         <= busy_n;
      timeout_flag <= timeout_flag_n;
      mem_read     <= mem_read_n;
      mem_write    <= mem_write_n;
      mem_addr     <= mem_addr_n;
      mem_wdata    <= mem_wdata_n;
      f_rdata      <= f_rdata_n;
      e_rdata      <= e_rdata_n;
      f_done       <= f_done_n;
      f_err        <= f_err_n;
      e_done       <= e_done_n;
      e_err        <= e_err_n;
    end
  end

  always_comb begin
    state_n        = state;
    streak_n       = streak;
    owner_n        = owner;
    timeout_flag_n = timeout_flag;
    mem_read_n     = mem_read;
    mem_write_n    = mem_write;
    mem_addr_n     = mem_addr;
    mem_wdata_n    = mem_wdata;
    f_rdata_n      = f_rdata;
    e_rdata_n      = e_rdata;
    f_done_n       = 1'b0;
    f_err_n        = 1'b0;
    e_done_n       = 1'b0;
    e_err_n        = 1'b0;
    grant_e        = 1'b0;
    grant_f        = 1'b0;
    tmo_clear      = 1'b0;
    tmo_en         = 1'b0;

    unique case (state)
      ST_IDLE: begin
        tmo_clear = 1'b1;
        // E loses a contested grant only once its streak has hit the limit
        grant_e = e_req && !(f_req && (streak == STREAK_MAX));
        grant_f = f_req && !grant_e;
        if (grant_e) begin
          owner_n     = OWNER_E;
          mem_addr_n  = e_addr;
          mem_wdata_n = e_wdata;
          mem_write_n = e_we;
          mem_read_n  = !e_we;
          state_n     = ST_BUSY;
          if (!f_req) begin
            streak_n = '0;
          end else if (streak != STREAK_MAX) begin
            streak_n = streak + 1'b1;
          end
        end else if (grant_f) begin
          owner_n     = OWNER_F;
          mem_addr_n  = f_addr;
          mem_write_n = 1'b0;
          mem_read_n  = 1'b1;
          streak_n    = '0;
          state_n     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mem_ready) begin
          if (owner == OWNER_F) begin
            f_rdata_n = mem_rdata;
            f_done_n  = 1'b1;
          end else begin
            if (!mem_write) e_rdata_n = mem_rdata;
            e_done_n = 1'b1;
          end
          mem_read_n  = 1'b0;
          mem_write_n = 1'b0;
          state_n     = ST_DONE;
        end else if (tmo_expired) begin
          if (owner == OWNER_F) f_err_n = 1'b1;
          else                  e_err_n = 1'b1;
          timeout_flag_n = 1'b1;
          mem_read_n     = 1'b0;
          mem_write_n    = 1'b0;
          state_n        = ST_DONE;
        end else begin
          tmo_en = 1'b1;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    busy_n = (state_n != ST_IDLE);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data/instruction memory port between instruction fetch (F, read-only) and the execute/store-back stage (E, load/store).
- Sequences each access through a request/ready handshake and pulses a one-cycle done back to the owning requester.
- E's done pulse is the valueReady equivalent.
- E has priority, bounded by an anti-starvation streak limit. A timeout guard aborts hung accesses.

Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 16, memory data width
- TIMEOUT_CYCLES, 16, BUSY cycles without mem_ready before abort (>=1)
- MAX_E_STREAK, 4, consecutive E grants allowed while F is pending (>=1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- f_req  in  1  fetch read request; level, held until f_done/f_err
- f_addr  in  ADDR_W  fetch address
- f_done  out  1  one-cycle pulse: f_rdata valid
- f_err  out  1  one-cycle pulse: fetch access timed out
- f_rdata  out  DATA_W  fetched word
- e_req  in  1  execute request; level, held until e_done/e_err
- e_we  in  1  1=store, 0=load
- e_addr  in  ADDR_W  load/store address
- e_wdata  in  DATA_W  store data
- e_done  out  1  one-cycle pulse: access complete, e_rdata valid on load
- e_err  out  1  one-cycle pulse: execute access timed out
- e_rdata  out  DATA_W  loaded word
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  memory completion; honoured only in BUSY
- busy  out  1  1 in BUSY or DONE
- owner  out  1  0=F, 1=E; the current/last grant
- timeout_flag  out  1  sticky; set on any timeout

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - All outputs 0, including strobes, data/address regs, streak counter, timeout counter and timeout_flag.
  - A reset mid-access drops strobes at once and discards the in-flight access; no done or err is issued.
- All outputs are registered.
- States: IDLE, BUSY, DONE.
- IDLE:
  - No request: stay.
  - Only one requester active: grant it.
  - Both active: grant E, unless streak==MAX_E_STREAK, in which case grant F.
  - On grant, at the same edge: latch addr/wdata into mem_addr/mem_wdata; assert mem_read (F, or E with e_we=0) or mem_write (E with e_we=1); set owner; clear timeout counter; go BUSY.
  - Request-to-strobe latency: 1 cycle.
- Streak counter:
  - +1 on an E grant while f_req=1.
  - Cleared on an F grant, or on an E grant while f_req=0.
  - Saturates at MAX_E_STREAK.
- BUSY:
  - Strobes and address held stable.
  - mem_ready=1: capture mem_rdata into the owner's rdata reg (loads/fetch only; e_rdata unchanged on a store), pulse the owner's done, drop strobes, go DONE.
  - Otherwise: timeout counter +1. When it reaches TIMEOUT_CYCLES, pulse the owner's err, set timeout_flag, drop strobes, go DONE.
  - mem_ready and the timeout on the same edge: mem_ready wins.
- DONE:
  - One cycle; done/err is high during it; unconditionally go IDLE.
  - The requester drops req on the edge where it samples done. IDLE samples req one edge later, so there is no double service.
  - Back-to-back grants: minimum 3 cycles/access with 1-cycle memory.
- Requests are sampled only in IDLE:
  - Changes to addr/we/wdata while BUSY are ignored.
  - A request deasserted before grant is simply not served.
- mem_ready in IDLE or DONE is ignored.
- The non-owner's done/err/rdata remain unchanged.
- timeout_flag is cleared only by rst.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding (IDLE/BUSY/DONE)
  - owner constants OWNER_F=0, OWNER_E=1
  - default ADDR_W/DATA_W
- One natural sub-module: mem_timeout_counter.
  - Width clog2(TIMEOUT_CYCLES+1).
  - Inputs clear/enable; output expired.

Test Plan:
- Fetch read, addr 0x10, memory returns 0xBEEF with mem_ready 3 cycles after strobe -> mem_read=1 and mem_addr=0x10 one cycle after f_req; f_done pulses 1 cycle with f_rdata=0xBEEF; mem_read=0 in DONE.
- Same-cycle f_req (addr 0x05) and e_req store (addr 0x20, data 0x1234) -> E served first: mem_write with 0x20/0x1234, e_done. F served next: f_done. owner sequence 1 then 0.
- e_req re-asserted after every e_done with f_req held high, MAX_E_STREAK=4 -> exactly 4 E grants, then F granted, streak cleared, then E resumes.
- E load with mem_ready never asserted, TIMEOUT_CYCLES=16 -> e_err after 16 BUSY cycles; timeout_flag=1 and stays 1; strobes drop; a following F access completes normally.
- rst asserted mid-BUSY (between clock edges) -> mem_read/mem_write fall immediately, timeout_flag cleared, no done/err; the next request is served from IDLE normally.
- mem_ready pulsed in IDLE with no request -> no done, no state change, rdata regs unchanged.
